fire2_squeeze_ofm_writer: RTL and testbench

// Downstream of fire2_squeeze: accepts each DSP_NO-wide ofm group (one output pixel,
// all squeeze channels) on fire2_squeeze_sample and applies ReLU. Serialises the group

---
 rtl/fire2_squeeze_ofm_writer.sv | 156 +++++++++++++++
 tb/tb_fire2_squeeze_ofm_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fire2_squeeze_ofm_writer.sv
// rtl/fire2_squeeze_ofm_writer.sv - ReLU and channel-major serialisation of fire2 squeeze ofm groups into RAM
module fire2_squeeze_ofm_writer #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 16,
    parameter int WOUT   = 64,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fire2_squeeze_en,
    input  logic                 i_fire2_squeeze_sample,
    input  logic [WIDTH-1:0]     i_ofm [0:DSP_NO-1],
    output logic                 o_ram_feedback,
    output logic                 o_wr_en,
    output logic [ADDR_W-1:0]    o_wr_addr,
    output logic [WIDTH-1:0]     o_wr_data,
    output logic                 o_wr_done,
    output logic                 o_overrun
);

    localparam int PIX  = WOUT * WOUT;
    localparam int CH_W = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PX_W = (PIX > 1) ? $clog2(PIX) : 1;

    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [PX_W-1:0]   PIX_LAST = PX_W'(PIX - 1);
    localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(PIX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ch_cnt;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [PX_W-1:0]     r_pix_cnt;
    logic [PX_W-1:0]     w_pix_nxt;
    logic [WIDTH-1:0]    r_shadow [0:DSP_NO-1];
    logic                w_capture;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic                r_ram_feedback;
    logic                r_wr_done;
    logic                r_overrun;

    logic                w_wr_en_nxt;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic [WIDTH-1:0]    w_wr_data_nxt;
    logic                w_fb_nxt;
    logic                w_done_nxt;
    logic                w_overrun_nxt;

    function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? '0 : x;
    endfunction

    // Outputs are computed one cycle ahead so every port comes straight from a flop;
    // channel 0 is taken directly from the input in the capture cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch_cnt;
        w_pix_nxt     = r_pix_cnt;
        w_capture     = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = '0;
        w_wr_data_nxt = '0;
        w_fb_nxt      = 1'b0;
        w_done_nxt    = r_wr_done;
        w_overrun_nxt = r_overrun | (i_fire2_squeeze_sample && (r_state != S_IDLE));

        case (r_state)
            S_IDLE: begin
                if (i_fire2_squeeze_sample) begin
                    w_capture     = 1'b1;
                    w_state_nxt   = S_WRITE;
                    w_ch_nxt      = '0;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = ADDR_W'(r_pix_cnt);
                    w_wr_data_nxt = relu(i_ofm[0]);
                end
            end
            S_WRITE: begin
                if (r_ch_cnt == CH_LAST) begin
                    w_state_nxt = S_ACK;
                    w_ch_nxt    = '0;
                    w_fb_nxt    = 1'b1;
                end else begin
                    w_ch_nxt      = r_ch_cnt + 1'b1;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_wr_addr + PIX_STEP;
                    w_wr_data_nxt = r_shadow[w_ch_nxt];
                end
            end
            S_ACK: begin
                if (r_pix_cnt == PIX_LAST) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_pix_nxt   = r_pix_cnt + 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_fire2_squeeze_en) begin
            r_state        <= S_IDLE;
            r_ch_cnt       <= '0;
            r_pix_cnt      <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_ram_feedback <= 1'b0;
            r_wr_done      <= 1'b0;
            r_overrun      <= 1'b0;
            // Soft clear via enable keeps the last captured group.
            if (i_rst) begin
                for (int i = 0; i < DSP_NO; i++) r_shadow[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_ch_cnt       <= w_ch_nxt;
            r_pix_cnt      <= w_pix_nxt;
            r_wr_en        <= w_wr_en_nxt;
            r_wr_addr      <= w_wr_addr_nxt;
            r_wr_data      <= w_wr_data_nxt;
            r_ram_feedback <= w_fb_nxt;
            r_wr_done      <= w_done_nxt;
            r_overrun      <= w_overrun_nxt;
            if (w_capture) begin
                for (int i = 0; i < DSP_NO; i++) r_shadow[i] <= relu(i_ofm[i]);
            end
        end
    end

    assign o_ram_feedback = r_ram_feedback;
    assign o_wr_en        = r_wr_en;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;
    assign o_wr_done      = r_wr_done;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_fire2_squeeze_ofm_writer.sv
// tb/tb_fire2_squeeze_ofm_writer.sv - directed self-checking bench for fire2_squeeze_ofm_writer
module tb_fire2_squeeze_ofm_writer;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 16;
    localparam int WOUT   = 64;
    localparam int ADDR_W = 16;
    localparam int PIX    = WOUT * WOUT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              sample = 1'b0;
    logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
    logic              ram_feedback;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_done;
    logic              overrun;

    logic [WIDTH-1:0]  exp_data [0:DSP_NO-1];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fire2_squeeze_ofm_writer #(
        .WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_fire2_squeeze_en     (en),
        .i_fire2_squeeze_sample (sample),
        .i_ofm                  (ofm),
        .o_ram_feedback         (ram_feedback),
        .o_wr_en                (wr_en),
        .o_wr_addr              (wr_addr),
        .o_wr_data              (wr_data),
        .o_wr_done              (wr_done),
        .o_overrun              (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? 16'h0000 : x;
    endfunction

    task automatic set_ofm_seq(input int base);
        for (int i = 0; i < DSP_NO; i++) begin
            ofm[i]      = 16'(base + i * 16'h0A31);
            exp_data[i] = relu(ofm[i]);
        end
    endtask

    // Drives one group starting at the next negedge and checks every output cycle.
    // glitch_at > 0 pulses an extra sample at T+glitch_at; abort_at > 0 asserts rst at T+abort_at.
    task automatic run_group(input int pix, input int glitch_at, input int abort_at);
        @(negedge clk);
        sample = 1'b1;
        for (int k = 1; k <= DSP_NO; k++) begin
            @(negedge clk);
            sample = (k == glitch_at);
            if (k == glitch_at) for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'h1234;
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, (k - 1) * PIX + pix);
            chk("wr_data", wr_data, exp_data[k-1]);
            chk("fb_low", ram_feedback, 0);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_wr_en", wr_en, 0);
                chk("abort_fb", ram_feedback, 0);
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk("abort_quiet_wr", wr_en, 0);
                    chk("abort_quiet_fb", ram_feedback, 0);
                end
                return;
            end
        end
        @(negedge clk);
        sample = 1'b0;
        chk("fb_pulse", ram_feedback, 1);
        chk("wr_en_after", wr_en, 0);
    endtask

    initial begin
        for (int i = 0; i < DSP_NO; i++) begin
            ofm[i] = '0;
            exp_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_fb", ram_feedback, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Test 1: ofm[i] = i+1 at pixel 0
        for (int i = 0; i < DSP_NO; i++) begin
            ofm[i] = 16'(i + 1);
            exp_data[i] = 16'(i + 1);
        end
        run_group(0, 0, 0);

        // Test 2: ReLU boundaries at pixel 1
        ofm[3] = 16'hFFFE; exp_data[3] = 16'h0000;
        ofm[5] = 16'h8000; exp_data[5] = 16'h0000;
        ofm[7] = 16'h0000; exp_data[7] = 16'h0000;
        ofm[9] = 16'h7FFF; exp_data[9] = 16'h7FFF;
        run_group(1, 0, 0);
        @(negedge clk);
        chk("t2_idle_wr", wr_en, 0);
        chk("t2_no_overrun", overrun, 0);

        // Test 4: second sample at T+5 ignored, still exactly 16 writes at pixel 2
        set_ofm_seq(16'h0100);
        run_group(2, 5, 0);
        @(negedge clk);
        chk("t4_overrun", overrun, 1);
        chk("t4_no_extra_wr", wr_en, 0);
        @(negedge clk);
        chk("t4_no_extra_wr2", wr_en, 0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("t4_overrun_clr", overrun, 0);
        set_ofm_seq(16'h0200);
        run_group(0, 0, 0);

        // Test 5: reset at T+8, then next group lands on pixel 0
        set_ofm_seq(16'h0300);
        run_group(1, 0, 8);
        set_ofm_seq(16'h0400);
        run_group(0, 0, 0);

        // Test 3: full map of 4096 pixels after a soft clear
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int p = 0; p < PIX; p++) begin
            set_ofm_seq(p * 7 + 16'h7000);
            chk("t3_done_low", wr_done, 0);
            run_group(p, 0, 0);
        end
        @(negedge clk);
        chk("t3_done", wr_done, 1);
        chk("t3_overrun", overrun, 0);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("done_no_wr", wr_en, 0);
        @(negedge clk);
        chk("done_no_wr2", wr_en, 0);
        chk("done_overrun", overrun, 1);
        chk("done_held", wr_done, 1);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("done_clr", wr_done, 0);
        chk("done_ovr_clr", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
